// File: rtl/stevej_pat_scheduler.sv
// Watchdog-style pat scheduler: supervised tasks check in over the bus, and a pat
// is issued inside the [PERIOD, DEADLINE) window. Optional STEVEJ_PAT_SCHED_HW_CHECKIN_EN.
module stevej_pat_scheduler #(
  parameter int NUM_TASKS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_OPEN = 3'd1,
    S_ARMED     = 3'd2,
    S_PAT       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  // Task slots beyond NUM_TASKS are held at zero so the 8-bit views stay clean.
  localparam logic [7:0] TASK_VALID = 8'((9'd1 << NUM_TASKS) - 9'd1);

  localparam logic [5:0] A_CTRL     = 6'h0;
  localparam logic [5:0] A_MASK     = 6'h1;
  localparam logic [5:0] A_CHECKIN  = 6'h2;
  localparam logic [5:0] A_PERIOD   = 6'h3;
  localparam logic [5:0] A_DEADLINE = 6'h4;
  localparam logic [5:0] A_STATUS   = 6'h5;
  localparam logic [5:0] A_PATCNT   = 6'h6;

  state_t      state;
  logic        enable;
  logic [7:0]  task_mask;
  logic [7:0]  flags;
  logic [31:0] period;
  logic [31:0] deadline;
  logic [31:0] counter;
  logic [31:0] pat_count;
  logic        pat;
  logic        armed;
  logic        fault;

  logic        wr;
  logic        wr_ctrl, wr_mask, wr_checkin, wr_period, wr_deadline;
  logic [31:0] cnt_nxt;
  logic [7:0]  checkin_set;
  logic [7:0]  missing;
  logic        all_in;

  assign wr          = (data_write_n != 2'b11);
  assign wr_ctrl     = wr && (address == A_CTRL);
  assign wr_mask     = wr && (address == A_MASK);
  assign wr_checkin  = wr && (address == A_CHECKIN);
  assign wr_period   = wr && (address == A_PERIOD);
  assign wr_deadline = wr && (address == A_DEADLINE);

  // Window decisions look at the value the counter takes this edge, so a state
  // change lands on the same edge the counter reaches the threshold.
  assign cnt_nxt = (counter == 32'hFFFF_FFFF) ? counter : counter + 32'd1;
  assign missing = task_mask & ~flags;
  assign all_in  = (missing == 8'h00);

`ifdef STEVEJ_PAT_SCHED_HW_CHECKIN_EN
  logic [3:0] ui_q;
`endif

  always_comb begin
    checkin_set = 8'h00;
    if (wr_checkin) checkin_set = data_in[7:0] & task_mask;
`ifdef STEVEJ_PAT_SCHED_HW_CHECKIN_EN
    checkin_set = checkin_set | ({ui_in[3:0] & ~ui_q, 4'b0000} & task_mask);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      enable    <= 1'b0;
      task_mask <= 8'h00;
      flags     <= 8'h00;
      period    <= 32'd0;
      deadline  <= 32'd0;
      counter   <= 32'd0;
      pat_count <= 32'd0;
      pat       <= 1'b0;
      armed     <= 1'b0;
      fault     <= 1'b0;
`ifdef STEVEJ_PAT_SCHED_HW_CHECKIN_EN
      ui_q      <= 4'h0;
`endif
    end else begin
`ifdef STEVEJ_PAT_SCHED_HW_CHECKIN_EN
      ui_q <= ui_in[3:0];
`endif
      if (wr_ctrl)                 enable    <= data_in[0];
      if (wr_mask && !enable)      task_mask <= data_in[7:0] & TASK_VALID;
      if (wr_period && !enable)    period    <= data_in;
      if (wr_deadline && !enable)  deadline  <= data_in;

      if (wr_ctrl && !data_in[0]) begin
        state   <= S_IDLE;
        counter <= 32'd0;
        flags   <= 8'h00;
        pat     <= 1'b0;
        armed   <= 1'b0;
        fault   <= 1'b0;
      end else if (wr_ctrl && data_in[1] && state == S_FAULT) begin
        state   <= S_WAIT_OPEN;
        counter <= 32'd0;
        flags   <= 8'h00;
        fault   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (enable) begin
              state   <= S_WAIT_OPEN;
              counter <= 32'd0;
              flags   <= 8'h00;
            end
          end
          S_WAIT_OPEN: begin
            counter <= cnt_nxt;
            flags   <= flags | checkin_set;
            if (cnt_nxt >= deadline) begin
              state <= S_FAULT;
              fault <= 1'b1;
            end else if (cnt_nxt >= period) begin
              state <= S_ARMED;
              armed <= 1'b1;
            end
          end
          S_ARMED: begin
            counter <= cnt_nxt;
            flags   <= flags | checkin_set;
            // Registered flags only: a check-in arriving on the deadline edge is late.
            if (all_in) begin
              state     <= S_PAT;
              armed     <= 1'b0;
              pat       <= 1'b1;
              pat_count <= pat_count + 32'd1;
            end else if (cnt_nxt >= deadline) begin
              state <= S_FAULT;
              armed <= 1'b0;
              fault <= 1'b1;
            end
          end
          S_PAT: begin
            state   <= S_WAIT_OPEN;
            pat     <= 1'b0;
            counter <= 32'd0;
            flags   <= 8'h00;
          end
          S_FAULT: begin
          end
          default: begin
            state   <= S_IDLE;
            counter <= 32'd0;
            flags   <= 8'h00;
            pat     <= 1'b0;
            armed   <= 1'b0;
            fault   <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    data_out = 32'd0;
    case (address)
      A_CTRL:     data_out = {31'd0, enable};
      A_MASK:     data_out = {24'd0, task_mask};
      A_CHECKIN:  data_out = {24'd0, flags};
      A_PERIOD:   data_out = period;
      A_DEADLINE: data_out = deadline;
      A_STATUS:   data_out = {21'd0, state, missing};
      A_PATCNT:   data_out = pat_count;
      default:    data_out = 32'd0;
    endcase
  end

  assign uo_out         = {3'b000, enable, armed, fault, pat, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = fault;

  // Read strobe carries no function; ui_in is only consumed by the hardware check-in path.
  logic unused_ok;
  assign unused_ok = &{1'b0, data_read_n, ui_in};

endmodule

// File: tb/tb_stevej_pat_scheduler.sv
// Directed bench for stevej_pat_scheduler: register access, pat window, deadline
// fault, clear/disable priority, reset abort, and the optional hardware check-in path.
module tb_stevej_pat_scheduler;
  logic        clk;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int checks   = 0;
  int failures = 0;

  stevej_pat_scheduler #(.NUM_TASKS(8)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    address      = a;
    data_in      = d;
    data_write_n = 2'b00;
    tick(1);
    data_write_n = 2'b11;
    data_in      = 32'd0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = data_out;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic chk_state(input string tag, input logic [2:0] exp);
    logic [31:0] v;
    rd(6'h5, v);
    chk(tag, {29'd0, v[10:8]}, {29'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; ui_in = 8'h00; address = 6'h0; data_in = 32'd0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_uo_out", {24'd0, uo_out}, 32'h0);
    chk("rst_irq", {31'd0, user_interrupt}, 32'h0);
    chk_rd("rst_ctrl", 6'h0, 32'h0);
    chk_rd("rst_status", 6'h5, 32'h0);
    chk_rd("rst_patcnt", 6'h6, 32'h0);
    chk("data_ready", {31'd0, data_ready}, 32'h1);

    // Normal pat: both tasks check in early, pat on the window opening.
    bus_write(6'h1, 32'h3);
    bus_write(6'h3, 32'd10);
    bus_write(6'h4, 32'd50);
    bus_write(6'h0, 32'h1);
    chk("en_uo_out", {24'd0, uo_out}, 32'h10);
    tick(1);
    chk_state("wait_open_entry", 3'd1);
    bus_write(6'h2, 32'h1);
    bus_write(6'h2, 32'h2);
    chk_rd("flags_accum", 6'h2, 32'h3);
    tick(7);
    chk_rd("pre_window_status", 6'h5, 32'h100);
    tick(1);
    chk("armed_uo_out", {24'd0, uo_out}, 32'h18);
    chk_rd("armed_status", 6'h5, 32'h200);
    tick(1);
    chk("pat_uo_out", {24'd0, uo_out}, 32'h12);
    chk_rd("pat_count_1", 6'h6, 32'd1);
    tick(1);
    chk("post_pat_uo_out", {24'd0, uo_out}, 32'h10);
    chk_rd("post_pat_status", 6'h5, 32'h103);
    chk_rd("post_pat_flags", 6'h2, 32'h0);

    // Missing task -> deadline fault, then clear_fault.
    bus_write(6'h0, 32'h0);
    chk_rd("disabled_status", 6'h5, 32'h003);
    bus_write(6'h0, 32'h1);
    tick(1);
    bus_write(6'h2, 32'h1);
    tick(48);
    chk_rd("pre_deadline_status", 6'h5, 32'h202);
    chk("pre_deadline_irq", {31'd0, user_interrupt}, 32'h0);
    tick(1);
    chk_rd("fault_status", 6'h5, 32'h402);
    chk("fault_irq", {31'd0, user_interrupt}, 32'h1);
    chk("fault_uo_out", {24'd0, uo_out}, 32'h14);
    bus_write(6'h2, 32'h2);
    chk_rd("fault_checkin_ignored", 6'h2, 32'h1);
    tick(3);
    chk_rd("fault_sticky", 6'h5, 32'h402);
    bus_write(6'h0, 32'h3);
    chk_rd("clear_status", 6'h5, 32'h103);
    chk("clear_irq", {31'd0, user_interrupt}, 32'h0);
    chk("clear_uo_out", {24'd0, uo_out}, 32'h10);
    chk_rd("ctrl_clear_reads0", 6'h0, 32'h1);

    // Empty mask: pat every PERIOD+2 cycles.
    bus_write(6'h0, 32'h0);
    bus_write(6'h1, 32'h0);
    bus_write(6'h3, 32'd4);
    bus_write(6'h0, 32'h1);
    tick(1);
    tick(4);
    chk("mask0_armed", {24'd0, uo_out}, 32'h18);
    tick(1);
    chk("mask0_pat1", {24'd0, uo_out}, 32'h12);
    chk_rd("mask0_count1", 6'h6, 32'd2);
    tick(1);
    chk("mask0_gap", {24'd0, uo_out}, 32'h10);
    tick(4);
    chk("mask0_armed2", {24'd0, uo_out}, 32'h18);
    tick(1);
    chk("mask0_pat2", {24'd0, uo_out}, 32'h12);
    chk_rd("mask0_count2", 6'h6, 32'd3);

    // Config locked while enabled; check-in filtering.
    bus_write(6'h0, 32'h0);
    bus_write(6'h1, 32'h3);
    bus_write(6'h3, 32'd10);
    bus_write(6'h4, 32'd50);
    bus_write(6'h0, 32'h1);
    tick(1);
    bus_write(6'h3, 32'd99);
    chk_rd("period_locked", 6'h3, 32'd10);
    bus_write(6'h1, 32'hFF);
    chk_rd("mask_locked", 6'h1, 32'h3);
    bus_write(6'h2, 32'h80);
    chk_rd("checkin_unmasked", 6'h2, 32'h0);
    bus_write(6'h2, 32'h1);
    chk_rd("checkin_set", 6'h2, 32'h1);
    bus_write(6'h2, 32'h0);
    chk_rd("checkin_no_clear", 6'h2, 32'h1);

    // Final check-in lands on the deadline edge: too late.
    bus_write(6'h0, 32'h0);
    bus_write(6'h3, 32'd2);
    bus_write(6'h4, 32'd8);
    bus_write(6'h0, 32'h1);
    tick(1);
    bus_write(6'h2, 32'h1);
    tick(6);
    chk_rd("late_pre_status", 6'h5, 32'h202);
    bus_write(6'h2, 32'h2);
    chk_state("late_fault_state", 3'd4);
    chk("late_fault_uo_out", {24'd0, uo_out}, 32'h14);
    tick(2);
    chk_rd("late_no_pat", 6'h6, 32'd3);
    chk_state("late_still_fault", 3'd4);
    bus_write(6'h0, 32'h2);
    chk_state("dis_beats_clear", 3'd0);
    chk("dis_clear_uo_out", {24'd0, uo_out}, 32'h0);
    chk("dis_clear_irq", {31'd0, user_interrupt}, 32'h0);
    chk_rd("dis_clear_ctrl", 6'h0, 32'h0);

    // Reset during PAT aborts with no further pat.
    bus_write(6'h1, 32'h0);
    bus_write(6'h3, 32'd4);
    bus_write(6'h0, 32'h1);
    tick(1);
    tick(5);
    chk("pre_reset_pat", {24'd0, uo_out}, 32'h12);
    chk_rd("pre_reset_count", 6'h6, 32'd4);
    rst_n = 1'b0;
    tick(1);
    chk("reset_uo_out", {24'd0, uo_out}, 32'h0);
    chk_rd("reset_patcnt", 6'h6, 32'd0);
    chk_rd("reset_period", 6'h3, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    chk("post_reset_uo_out", {24'd0, uo_out}, 32'h0);
    chk_rd("post_reset_status", 6'h5, 32'h0);
    chk_rd("unmapped_07", 6'h07, 32'h0);
    chk_rd("unmapped_3f", 6'h3F, 32'h0);

`ifdef STEVEJ_PAT_SCHED_HW_CHECKIN_EN
    // Hardware check-in: one edge sets flag 4; a held level does not re-trigger.
    bus_write(6'h1, 32'h10);
    bus_write(6'h3, 32'd3);
    bus_write(6'h4, 32'd50);
    bus_write(6'h0, 32'h1);
    tick(1);
    ui_in = 8'h01;
    tick(1);
    chk_rd("hw_flag4", 6'h2, 32'h10);
    tick(2);
    chk("hw_armed", {24'd0, uo_out}, 32'h18);
    tick(1);
    chk("hw_pat", {24'd0, uo_out}, 32'h12);
    chk_rd("hw_count", 6'h6, 32'd1);
    tick(7);
    chk_rd("hw_no_retrigger", 6'h5, 32'h210);
    chk_rd("hw_count_held", 6'h6, 32'd1);
    ui_in = 8'h00;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
